mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the shared cache/RAM memory system: 6-bit address, 8-bit data, with a `hit` output. Port 0 (instruction fetch, read-only) and port 1 (data, read/write) compete for the memory system. The block grants round-robin, holds the address stable across cache-miss fill time, captures read data, and returns a one-cycle acknowledge to the winner. It also keeps saturating hit/miss statistics.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and access sequencer for the shared cache/RAM
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req0/addr0          port 0 read request (instruction fetch); ack0/rdata0 response
//   req1/we1/addr1/wdata1  port 1 read/write request; ack1/rdata1 response
//   mem_address/mem_writedata/mem_writeen  toward the memory system, driven from latched registers
//   mem_hit/mem_readdata                   from the memory system
//   busy                any state other than IDLE
//   grant               port owning the current or most recent transaction
//   hit_cnt/miss_cnt    saturating read hit/miss statistics

module mem_arbiter #(
    parameter int unsigned MISS_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [5:0] addr0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [5:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic [5:0] mem_address,
    output logic [7:0] mem_writedata,
    output logic       mem_writeen,
    input  logic       mem_hit,
    input  logic [7:0] mem_readdata,
    output logic       busy,
    output logic       grant,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt
);

    localparam logic [3:0] LAT = 4'(MISS_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  miss_q, miss_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        win;
    logic        capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // port 0 wins the first tie
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        cnt_d        = cnt_q;
        win          = 1'b0;
        capture      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not own the last transaction wins.
                    win          = (req0 && req1) ? ~last_grant_q : req1;
                    addr_d       = win ? addr1 : addr0;
                    we_d         = win & we1;
                    wdata_d      = win ? wdata1 : 8'h00;
                    grant_d      = win;
                    last_grant_d = win;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (mem_hit) begin
                    capture = 1'b1;
                    if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
                    state_d = RESP;
                end else begin
                    if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
                    cnt_d   = LAT;
                    state_d = FILL;
                end
            end
            FILL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only the granted port's read data register is ever touched.
        if (capture) begin
            if (grant_q) rdata1_d = mem_readdata;
            else         rdata0_d = mem_readdata;
        end
    end

    assign ack0          = (state_q == RESP) && !grant_q;
    assign ack1          = (state_q == RESP) &&  grant_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign mem_writeen   = (state_q == ACCESS) && we_q;
    assign busy          = (state_q != IDLE);
    assign grant         = grant_q;
    assign hit_cnt       = hit_q;
    assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter with a transaction-level reference model

module tb_mem_arbiter;

    localparam int MISS_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic [5:0] addr0 = '0;
    logic       ack0;
    logic [7:0] rdata0;
    logic       req1 = 1'b0;
    logic       we1 = 1'b0;
    logic [5:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic       ack1;
    logic [7:0] rdata1;
    logic [5:0] mem_address;
    logic [7:0] mem_writedata;
    logic       mem_writeen;
    logic       mem_hit;
    logic [7:0] mem_readdata;
    logic       busy;
    logic       grant;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    mem_arbiter #(.MISS_LAT(MISS_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_writeen(mem_writeen),
        .mem_hit(mem_hit), .mem_readdata(mem_readdata),
        .busy(busy), .grant(grant), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Memory system stand-in: contents follow a fixed formula at start, then take DUT writes.
    logic [7:0] mem_arr [64];
    bit         hit_map [64];
    assign mem_readdata = mem_arr[mem_address];
    assign mem_hit      = hit_map[mem_address];

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = 8'(i * 37 + 5);
        forever begin
            @(negedge clk);
            if (mem_writeen) mem_arr[mem_address] = mem_writedata;
        end
    end

    typedef struct {
        bit         port;
        logic [7:0] rd0;
        logic [7:0] rd1;
        int         cyc;
        int         hc;
        int         mc;
        int         wen;
        logic [5:0] addr;
        logic [7:0] wd;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0] ref_mem [64];
    bit         m_last = 1'b1;
    int         m_hit = 0;
    int         m_miss = 0;
    logic [7:0] m_rd0 = '0;
    logic [7:0] m_rd1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_hit  = 0;
        m_miss = 0;
        m_rd0  = '0;
        m_rd1  = '0;
        exp_q.delete();
    endtask

    // Decide the winner among the currently held requests and predict its response.
    task automatic predict(output bit w);
        exp_t e;
        logic [5:0] a;
        w = (req0 && req1) ? ~m_last : req1;
        m_last = w;
        e.port = w;
        e.wen  = 0;
        e.wd   = '0;
        if (w && we1) begin
            ref_mem[addr1] = wdata1;
            e.wen  = 1;
            e.wd   = wdata1;
            e.addr = addr1;
            e.cyc  = cyc + 2;
        end else begin
            a = w ? addr1 : addr0;
            e.addr = a;
            if (hit_map[a]) begin
                m_hit = (m_hit == 255) ? 255 : m_hit + 1;
                e.cyc = cyc + 2;
            end else begin
                m_miss = (m_miss == 255) ? 255 : m_miss + 1;
                e.cyc  = cyc + 2 + MISS_LAT;
            end
            if (w) m_rd1 = ref_mem[a];
            else   m_rd0 = ref_mem[a];
        end
        e.rd0 = m_rd0;
        e.rd1 = m_rd1;
        e.hc  = m_hit;
        e.mc  = m_miss;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per acknowledge.
    exp_t mon_e;
    int   wen_seen = 0;
    always @(negedge clk) begin
        if (!reset) begin
            wen_seen = 0;
        end else begin
            if (mem_writeen) begin
                wen_seen++;
                if (exp_q.size() > 0) begin
                    chk("wr_addr", 32'(mem_address), 32'(exp_q[0].addr));
                    chk("wr_data", 32'(mem_writedata), 32'(exp_q[0].wd));
                end
            end
            if (ack0 || ack1) begin
                chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d expected none (cycle %0d)", ack0, ack1, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_port", 32'(ack1), 32'(mon_e.port));
                    chk("grant", 32'(grant), 32'(mon_e.port));
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("rdata0", 32'(rdata0), 32'(mon_e.rd0));
                    chk("rdata1", 32'(rdata1), 32'(mon_e.rd1));
                    chk("hit_cnt", 32'(hit_cnt), 32'(mon_e.hc));
                    chk("miss_cnt", 32'(miss_cnt), 32'(mon_e.mc));
                    chk("mem_address", 32'(mem_address), 32'(mon_e.addr));
                    chk("writeen_cycles", 32'(wen_seen), 32'(mon_e.wen));
                end
                wen_seen = 0;
            end
        end
    end

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Serve up to n transactions from the held requests. With keep=0 the winner
    // drops its request on ack; the final transaction always clears both.
    task automatic run_txns(input int n, input bit keep);
        bit w;
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (!(req0 || req1)) break;
            predict(w);
            wait_ack(ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL ack_timeout: got no ack within 40 cycles expected ack%0d", w);
                finish_run();
            end
            if (!keep) begin
                if (w) req1 = 1'b0;
                else   req0 = 1'b0;
            end
            if (i == n - 1) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ack0"}, 32'(ack0), 32'd0);
        chk({tag, "_ack1"}, 32'(ack1), 32'd0);
        chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, "_mem_writedata"}, 32'(mem_writedata), 32'd0);
        chk({tag, "_mem_writeen"}, 32'(mem_writeen), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
        chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
    endtask

    initial begin
        logic [1:0] r;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'(i * 37 + 5);
            hit_map[i] = bit'($urandom_range(0, 1));
        end

        // Power-on reset
        repeat (3) @(negedge clk);
        check_cleared("por");
        reset = 1'b1;

        // Directed: preload 0x12 with 0x5A, then port 0 read hit
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'h12; wdata1 = 8'h5A;
        run_txns(1, 1'b0);
        hit_map[6'h12] = 1'b1;
        req0 = 1'b1; addr0 = 6'h12;
        run_txns(1, 1'b0);

        // Directed: preload 0x07 with 0x33, then port 1 read miss
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'h07; wdata1 = 8'h33;
        run_txns(1, 1'b0);
        hit_map[6'h07] = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'h07;
        run_txns(1, 1'b0);

        // Directed: port 1 write 0x3F <- 0xA5
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'h3F; wdata1 = 8'hA5;
        run_txns(1, 1'b0);

        // Contention: both requests held for several transactions
        addr0 = 6'($urandom); addr1 = 6'($urandom); we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        run_txns(6, 1'b1);

        // Randomized mix
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            addr0  = 6'($urandom);
            addr1  = 6'($urandom);
            wdata1 = 8'($urandom);
            we1    = 1'($urandom);
            r      = 2'($urandom_range(1, 3));
            req0   = r[0];
            req1   = r[1];
            run_txns(2, 1'b0);
        end

        // Reset during FILL: no ack, then the held request is re-served
        hit_map[6'h20] = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'h20;
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_fill", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_cleared("rst_fill");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_txns(1, 1'b0);

        // Saturation of the hit counter
        for (int k = 0; k < 300; k++) begin
            addr0 = 6'($urandom);
            hit_map[addr0] = 1'b1;
            req0 = 1'b1;
            run_txns(1, 1'b0);
        end
        chk("hit_saturated", 32'(hit_cnt), 32'd255);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        finish_run();
    end

endmodule
